// File: rtl/config_ram_pkg.sv
// Shared definitions for the interface config RAM and its port-B arbiter.
package config_ram_pkg;

  // Config RAM geometry
  localparam int CFG_AWIDTH = 4;
  localparam int CFG_DWIDTH = 512;
  localparam int CFG_DEPTH  = 16;

  // Requester indices on the arbiter
  localparam int CFG_REQ_COUNT = 2;
  localparam int REQ_RX        = 0;
  localparam int REQ_TX        = 1;

  // Width of a requester id, never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_ID_W = id_width(CFG_REQ_COUNT);

endpackage

// File: rtl/config_ram_arb_if.sv
// Requester-side bundle of the config RAM arbiter: valid/ready requests out,
// one-hot read responses back.
interface config_ram_arb_if
  import config_ram_pkg::*;
#(
  parameter int REQ_COUNT = CFG_REQ_COUNT,
  parameter int AWIDTH    = CFG_AWIDTH,
  parameter int DWIDTH    = CFG_DWIDTH
);

  logic [REQ_COUNT-1:0]        s_req_valid;
  logic [REQ_COUNT-1:0]        s_req_ready;
  logic [REQ_COUNT-1:0]        s_req_we;
  logic [REQ_COUNT-1:0]        s_req_lock;
  logic [REQ_COUNT*AWIDTH-1:0] s_req_addr;
  logic [REQ_COUNT*DWIDTH-1:0] s_req_wdata;
  logic [REQ_COUNT-1:0]        m_rsp_valid;
  logic [DWIDTH-1:0]           m_rsp_rdata;

  // Requesters drive requests and consume grants and responses
  modport master (
    output s_req_valid, s_req_we, s_req_lock, s_req_addr, s_req_wdata,
    input  s_req_ready, m_rsp_valid, m_rsp_rdata
  );

  // The arbiter consumes requests and drives grants and responses
  modport slave (
    input  s_req_valid, s_req_we, s_req_lock, s_req_addr, s_req_wdata,
    output s_req_ready, m_rsp_valid, m_rsp_rdata
  );

endinterface

// File: rtl/config_ram_arb_rr_lock_arb.sv
// Round-robin winner search with a sticky lock for read-modify-write
// sequences. The grant is combinational; ptr/locked/owner are registered.
module rr_lock_arb
  import config_ram_pkg::*;
#(
  parameter int REQ_COUNT = CFG_REQ_COUNT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQ_COUNT-1:0]             i_valid,
  input  logic [REQ_COUNT-1:0]             i_lock,
  output logic [REQ_COUNT-1:0]             o_grant,
  output logic                             o_hs,
  output logic [id_width(REQ_COUNT)-1:0]   o_win_id
);

  localparam int IDW = id_width(REQ_COUNT);

  logic [IDW-1:0] r_ptr;
  logic           r_locked;
  logic [IDW-1:0] r_owner;

  logic [IDW-1:0] w_ptr_nxt;
  logic           w_locked_nxt;
  logic [IDW-1:0] w_owner_nxt;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  int             w_idx_int;

  // Pick the winner: the owner alone while locked, else first valid from ptr
  always_comb begin
    w_found   = 1'b0;
    w_win     = {IDW{1'b0}};
    w_idx     = {IDW{1'b0}};
    w_idx_int = 0;
    if (rst) begin
      w_found = 1'b0;
    end else if (r_locked) begin
      if (i_valid[r_owner]) begin
        w_found = 1'b1;
        w_win   = r_owner;
      end else begin
        w_found = 1'b0;
      end
    end else begin
      for (int k = 0; k < REQ_COUNT; k++) begin
        w_idx_int = int'(r_ptr) + k;
        if (w_idx_int >= REQ_COUNT) begin
          w_idx_int = w_idx_int - REQ_COUNT;
        end else begin
          w_idx_int = w_idx_int;
        end
        w_idx = w_idx_int[IDW-1:0];
        if (!w_found && i_valid[w_idx]) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end else begin
          w_found = w_found;
        end
      end
    end
  end

  // Next priority state: lock onto the winner, or rotate past it on release
  always_comb begin
    w_ptr_nxt    = r_ptr;
    w_locked_nxt = r_locked;
    w_owner_nxt  = r_owner;
    if (w_found) begin
      if (i_lock[w_win]) begin
        w_locked_nxt = 1'b1;
        w_owner_nxt  = w_win;
      end else begin
        w_locked_nxt = 1'b0;
        if (int'(w_win) + 1 >= REQ_COUNT) begin
          w_ptr_nxt = {IDW{1'b0}};
        end else begin
          w_ptr_nxt = w_win + {{(IDW-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  // Priority state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= {IDW{1'b0}};
      r_locked <= 1'b0;
      r_owner  <= {IDW{1'b0}};
    end else begin
      r_ptr    <= w_ptr_nxt;
      r_locked <= w_locked_nxt;
      r_owner  <= w_owner_nxt;
    end
  end

  // One-hot grant on the winner
  always_comb begin
    o_grant = {REQ_COUNT{1'b0}};
    if (w_found) begin
      o_grant[w_win] = 1'b1;
    end else begin
      o_grant = {REQ_COUNT{1'b0}};
    end
  end

  assign o_hs     = w_found;
  assign o_win_id = w_win;

endmodule

// File: rtl/config_ram_arb.sv
// Shares config RAM port B between RX/TX (and further) requesters: one access
// per cycle, registered RAM command, read tags delayed to match RAM latency.
module config_ram_arb
  import config_ram_pkg::*;
#(
  parameter int REQ_COUNT      = CFG_REQ_COUNT,
  parameter int AWIDTH         = CFG_AWIDTH,
  parameter int DWIDTH         = CFG_DWIDTH,
  parameter int RAM_RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  config_ram_arb_if.slave     req_if,
  output logic                ram_en,
  output logic                ram_we,
  output logic [AWIDTH-1:0]   ram_addr,
  output logic [DWIDTH-1:0]   ram_wdata,
  input  logic [DWIDTH-1:0]   ram_rdata
);

  localparam int IDW        = id_width(REQ_COUNT);
  localparam int TAG_STAGES = RAM_RD_LATENCY + 1;

  logic [REQ_COUNT-1:0] w_grant;
  logic                 w_hs;
  logic [IDW-1:0]       w_win_id;
  logic                 w_win_we;
  logic [AWIDTH-1:0]    w_win_addr;
  logic [DWIDTH-1:0]    w_win_wdata;
  logic [REQ_COUNT-1:0] w_rsp_valid;

  logic                 r_ram_en;
  logic                 r_ram_we;
  logic [AWIDTH-1:0]    r_ram_addr;
  logic [DWIDTH-1:0]    r_ram_wdata;

  // One tag per cycle; the last stage lines up with valid ram_rdata
  logic [TAG_STAGES-1:0] r_tag_vld;
  logic [IDW-1:0]        r_tag_id [TAG_STAGES];

  rr_lock_arb #(.REQ_COUNT(REQ_COUNT)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (req_if.s_req_valid),
    .i_lock   (req_if.s_req_lock),
    .o_grant  (w_grant),
    .o_hs     (w_hs),
    .o_win_id (w_win_id)
  );

  assign w_win_we    = req_if.s_req_we[w_win_id];
  assign w_win_addr  = req_if.s_req_addr[w_win_id*AWIDTH +: AWIDTH];
  assign w_win_wdata = req_if.s_req_wdata[w_win_id*DWIDTH +: DWIDTH];

  // RAM command: strobe en/we per handshake, hold addr/wdata otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= {AWIDTH{1'b0}};
      r_ram_wdata <= {DWIDTH{1'b0}};
    end else if (w_hs) begin
      r_ram_en    <= 1'b1;
      r_ram_we    <= w_win_we;
      r_ram_addr  <= w_win_addr;
      r_ram_wdata <= w_win_wdata;
    end else begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
    end
  end

  // Read tag shift register; reset drops every in-flight read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= {TAG_STAGES{1'b0}};
      for (int s = 0; s < TAG_STAGES; s++) begin
        r_tag_id[s] <= {IDW{1'b0}};
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[TAG_STAGES-2:0], w_hs & ~w_win_we};
      r_tag_id[0] <= w_win_id;
      for (int s = 1; s < TAG_STAGES; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Decode the oldest tag into the one-hot response strobe
  always_comb begin
    w_rsp_valid = {REQ_COUNT{1'b0}};
    if (r_tag_vld[RAM_RD_LATENCY]) begin
      w_rsp_valid[r_tag_id[RAM_RD_LATENCY]] = 1'b1;
    end else begin
      w_rsp_valid = {REQ_COUNT{1'b0}};
    end
  end

  assign req_if.s_req_ready = w_grant;
  assign req_if.m_rsp_valid = w_rsp_valid;
  assign req_if.m_rsp_rdata = ram_rdata;

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_config_ram_arb.sv
// Bench for config_ram_arb: directed scenarios plus random traffic against a
// request-level reference model, with a queue-based response scoreboard.
module tb_config_ram_arb;
  import config_ram_pkg::*;

  localparam int N  = CFG_REQ_COUNT;
  localparam int AW = CFG_AWIDTH;
  localparam int DW = CFG_DWIDTH;
  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  config_ram_arb_if #(.REQ_COUNT(N), .AWIDTH(AW), .DWIDTH(DW)) bus1 ();
  config_ram_arb_if #(.REQ_COUNT(N), .AWIDTH(AW), .DWIDTH(DW)) bus3 ();

  logic          ram_en1, ram_we1, ram_en3, ram_we3;
  logic [AW-1:0] ram_addr1, ram_addr3;
  logic [DW-1:0] ram_wdata1, ram_rdata1, ram_wdata3, ram_rdata3;

  config_ram_arb #(.REQ_COUNT(N), .AWIDTH(AW), .DWIDTH(DW), .RAM_RD_LATENCY(L1)) u_dut1 (
    .clk(clk), .rst(rst), .req_if(bus1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  config_ram_arb #(.REQ_COUNT(N), .AWIDTH(AW), .DWIDTH(DW), .RAM_RD_LATENCY(L3)) u_dut3 (
    .clk(clk), .rst(rst), .req_if(bus3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  // Behavioural RAMs with read latency L1 / L3
  logic [DW-1:0] mem1 [CFG_DEPTH];
  logic [DW-1:0] pipe1 [L1];
  logic [DW-1:0] mem3 [CFG_DEPTH];
  logic [DW-1:0] pipe3 [L3];

  always @(posedge clk) begin
    if (ram_en1 && ram_we1) mem1[ram_addr1] <= ram_wdata1;
    if (ram_en1 && !ram_we1) pipe1[0] <= mem1[ram_addr1];
    for (int k = 1; k < L1; k++) pipe1[k] <= pipe1[k-1];
  end
  assign ram_rdata1 = pipe1[L1-1];

  always @(posedge clk) begin
    if (ram_en3 && ram_we3) mem3[ram_addr3] <= ram_wdata3;
    if (ram_en3 && !ram_we3) pipe3[0] <= mem3[ram_addr3];
    for (int k = 1; k < L3; k++) pipe3[k] <= pipe3[k-1];
  end
  assign ram_rdata3 = pipe3[L3-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]  ready;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  typedef struct {
    int            issue;
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rsp_t;

  exp_t exp_q [$];
  rsp_t rsp_q [$];
  rsp_t rsp3_q [$];

  int checks = 0;
  int fails  = 0;

  // Reference model state, described at request level
  int            m_ptr    = 0;
  int            m_owner  = 0;
  bit            m_locked = 1'b0;
  logic          m_en     = 1'b0;
  logic          m_we     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [DW-1:0] m_wdata  = '0;
  logic [DW-1:0] ref_mem [CFG_DEPTH];
  int            last_rst = -100;

  // Model: predict this cycle's grant/RAM outputs and queue read responses
  always @(negedge clk) begin
    exp_t e;
    rsp_t r;
    int   w;
    e.ready = '0;
    e.en    = m_en;
    e.we    = m_we;
    e.addr  = m_addr;
    e.wdata = m_wdata;
    if (rst) begin
      m_ptr = 0; m_locked = 1'b0; m_owner = 0;
      m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      last_rst = cyc;
    end else begin
      w = -1;
      if (m_locked) begin
        if (bus1.s_req_valid[m_owner]) w = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (w < 0 && bus1.s_req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      if (w >= 0) begin
        e.ready[w] = 1'b1;
        m_en    = 1'b1;
        m_we    = bus1.s_req_we[w];
        m_addr  = bus1.s_req_addr[w*AW +: AW];
        m_wdata = bus1.s_req_wdata[w*DW +: DW];
        if (m_we) begin
          ref_mem[m_addr] = m_wdata;
        end else begin
          r.issue = cyc; r.due = cyc + 1 + L1; r.id = w; r.data = ref_mem[m_addr];
          rsp_q.push_back(r);
        end
        if (bus1.s_req_lock[w]) begin
          m_locked = 1'b1; m_owner = w;
        end else begin
          m_locked = 1'b0; m_ptr = (w + 1) % N;
        end
      end else begin
        m_en = 1'b0; m_we = 1'b0;
      end
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectations
  always @(negedge clk) begin
    exp_t e;
    rsp_t r;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ready",     bus1.s_req_ready, e.ready);
      chk("ram_en",    ram_en1,          e.en);
      chk("ram_we",    ram_we1,          e.we);
      chk("ram_addr",  ram_addr1,        e.addr);
      chk("ram_wdata", ram_wdata1,       e.wdata);
    end
    while (rsp_q.size() > 0 && rsp_q[0].issue < last_rst && rsp_q[0].due > last_rst)
      void'(rsp_q.pop_front());
    if (bus1.m_rsp_valid != '0) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", bus1.m_rsp_valid, 0);
      end else begin
        r = rsp_q.pop_front();
        chk("rsp_cycle", cyc,              r.due);
        chk("rsp_id",    bus1.m_rsp_valid, 1 << r.id);
        chk("rsp_data",  bus1.m_rsp_rdata, r.data);
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      chk("rsp_missing", bus1.m_rsp_valid, 1 << r.id);
    end
    if (bus3.m_rsp_valid != '0) begin
      if (rsp3_q.size() == 0) begin
        chk("lat3_unexpected", bus3.m_rsp_valid, 0);
      end else begin
        r = rsp3_q.pop_front();
        chk("lat3_cycle", cyc,              r.due);
        chk("lat3_id",    bus3.m_rsp_valid, 1 << r.id);
        chk("lat3_data",  bus3.m_rsp_rdata, r.data);
      end
    end else if (rsp3_q.size() > 0 && rsp3_q[0].due <= cyc) begin
      r = rsp3_q.pop_front();
      chk("lat3_missing", bus3.m_rsp_valid, 1 << r.id);
    end
  end

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Present one cycle of requests on the latency-1 DUT
  task automatic drv(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] lk,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bus1.s_req_valid = v;
    bus1.s_req_we    = we;
    bus1.s_req_lock  = lk;
    bus1.s_req_addr  = {a1, a0};
    bus1.s_req_wdata = {d1, d0};
    @(posedge clk); #1;
  endtask

  // Present one cycle of an RX request on the latency-3 DUT
  task automatic drv3(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus3.s_req_valid = {1'b0, v};
    bus3.s_req_we    = {1'b0, we};
    bus3.s_req_lock  = '0;
    bus3.s_req_addr  = {{AW{1'b0}}, a};
    bus3.s_req_wdata = {{DW{1'b0}}, d};
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv('0, '0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] pat_a5;
    logic [DW-1:0] d3;
    rsp_t          r3;
    pat_a5 = {64{8'hA5}};
    bus1.s_req_valid = '0; bus1.s_req_we = '0; bus1.s_req_lock = '0;
    bus1.s_req_addr = '0; bus1.s_req_wdata = '0;
    bus3.s_req_valid = '0; bus3.s_req_we = '0; bus3.s_req_lock = '0;
    bus3.s_req_addr = '0; bus3.s_req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Fill every RAM word through RX; addr 3 gets the A5 pattern
    for (int a = 0; a < CFG_DEPTH; a++)
      drv(2'b01, 2'b01, 2'b00, a[AW-1:0], '0, (a == 3) ? pat_a5 : rnd512(), '0);
    idle(2);

    // Single RX read of addr 3
    drv(2'b01, 2'b00, 2'b00, 4'd3, '0, '0, '0);
    idle(3);

    // Contention: RX reads 1, TX reads 2, both always valid
    for (int i = 0; i < 8; i++) drv(2'b11, 2'b00, 2'b00, 4'd1, 4'd2, '0, '0);
    idle(3);

    // Lock: TX locked read of 5, RX waits, TX unlocking write of 5, RX next
    drv(2'b10, 2'b00, 2'b10, '0, 4'd5, '0, '0);
    drv(2'b01, 2'b00, 2'b00, 4'd0, 4'd5, '0, '0);
    drv(2'b01, 2'b00, 2'b00, 4'd0, 4'd5, '0, '0);
    drv(2'b11, 2'b10, 2'b00, 4'd0, 4'd5, '0, rnd512());
    drv(2'b01, 2'b00, 2'b00, 4'd0, 4'd5, '0, '0);
    idle(3);

    // Write-then-read: TX writes 7, RX reads 7 the next cycle
    drv(2'b10, 2'b10, 2'b00, '0, 4'd7, '0, {{(DW-16){1'b0}}, 16'h1234});
    drv(2'b01, 2'b00, 2'b00, 4'd7, '0, '0, '0);
    idle(3);

    // Reset the cycle after a read handshake; then RX must win first
    drv(2'b01, 2'b00, 2'b00, 4'd4, '0, '0, '0);
    rst = 1'b1;
    drv(2'b11, 2'b00, 2'b00, 4'd1, 4'd2, '0, '0);
    rst = 1'b0;
    drv(2'b11, 2'b00, 2'b00, 4'd1, 4'd2, '0, '0);
    drv(2'b11, 2'b00, 2'b00, 4'd1, 4'd2, '0, '0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      drv($urandom_range(0, 3), $urandom_range(0, 3),
          {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
          $urandom_range(0, 15), $urandom_range(0, 15), rnd512(), rnd512());
    idle(6);

    // Latency-3 build: write addr 3, read it back, response 4 cycles later
    d3 = rnd512();
    drv3(1'b1, 1'b1, 4'd3, d3);
    r3.issue = cyc; r3.due = cyc + 1 + L3; r3.id = REQ_RX; r3.data = d3;
    rsp3_q.push_back(r3);
    drv3(1'b1, 1'b0, 4'd3, '0);
    for (int i = 0; i < 10; i++) drv3(1'b0, 1'b0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/config_ram_arb.md
# config_ram_arb

Round-robin arbiter that shares the single read/write port B of the 16-entry × 512-bit interface config RAM between the RX and TX data-processing pipelines. Any further config-RAM clients attach here too. It accepts valid/ready requests, issues at most one RAM access per cycle, and tracks in-flight reads through a tag pipeline matched to the RAM output delay. It routes each read response back to the requester that issued it. Port A of the RAM stays owned by the AXI-lite control path and is outside this block.

## Interface
- REQ_COUNT, 2, number of requesters (index 0 = RX, 1 = TX)
- AWIDTH, 4, config RAM address width
- DWIDTH, 512, config RAM data width
- RAM_RD_LATENCY, 1, cycles from ram_en to valid ram_rdata (RAM OUT_DELAY), range 1–4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_req_valid  in  REQ_COUNT  per-requester request valid
- s_req_ready  out  REQ_COUNT  per-requester grant; a handshake occurs when valid&&ready
- s_req_we  in  REQ_COUNT  1 = write, 0 = read
- s_req_lock  in  REQ_COUNT  keep the grant on this requester after this handshake (read-modify-write)
- s_req_addr  in  REQ_COUNT*AWIDTH  packed addresses
- s_req_wdata  in  REQ_COUNT*DWIDTH  packed write data
- m_rsp_valid  out  REQ_COUNT  one-cycle read-response strobe, one-hot; no backpressure
- m_rsp_rdata  out  DWIDTH  shared response data, valid when any m_rsp_valid bit is set
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AWIDTH  RAM address
- ram_wdata  out  DWIDTH  RAM write data
- ram_rdata  in  DWIDTH  RAM read data

## Operation
- Winner selection is combinational each cycle. The block searches requesters with valid=1 starting at the priority pointer `ptr`, wrapping modulo REQ_COUNT. s_req_ready is one-hot on the winner and all-zero when no requester is valid or when rst=1.
- Pointer update on a handshake by requester i:
  - If lock=0, `ptr` becomes (i+1) mod REQ_COUNT.
  - If lock=1, `locked`=1 and `owner`=i.
- While `locked`=1, only `owner` can be granted; other requesters see ready=0 even while owner is idle. The lock clears on an owner handshake with lock=0, and `ptr` then advances past the owner.
- On a handshake, the RAM command registers are loaded on the next edge: ram_en=1, ram_we, ram_addr and ram_wdata take the winner's fields. With no handshake, ram_en=0 and ram_we=0; addr/wdata hold their values.
- Read tag pipeline:
  - Each read handshake pushes {valid=1, id=i} into a RAM_RD_LATENCY+1-stage shift register; writes and idle cycles push valid=0.
  - The tag output drives m_rsp_valid (one-hot decode of id), and m_rsp_rdata = ram_rdata passthrough.
- Writes produce no response.
- Ordering: accesses reach the RAM in handshake order. A read handshaken the cycle after a write to the same address returns the new data.
- Throughput is one access per cycle. Back-to-back handshakes from the same requester are allowed only while it holds the lock or is the only valid requester.

## Timing
- Reset values: s_req_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, m_rsp_valid=0, ptr=0, locked=0, owner=0, all tags invalid.
- Read latency: handshake in cycle n → ram_en in cycle n+1 → m_rsp_valid in cycle n+1+RAM_RD_LATENCY (n+2 with the default).
- Write: handshake in cycle n → ram_en=ram_we=1 in cycle n+1.
- Reset mid-operation: all in-flight tags are dropped and outstanding reads never respond. Requesters must discard their outstanding reads on rst.
- Simultaneous valid from all requesters: exactly one handshake per cycle, with grants rotating 0,1,0,1…

## Structure
- Shared package `config_ram_pkg`:
  - RAM geometry constants (AWIDTH=4, DWIDTH=512, depth 16)
  - requester index constants (REQ_RX=0, REQ_TX=1)
  - requester-id width $clog2(REQ_COUNT)
- One sub-module `rr_lock_arb`: the combinational winner search plus the ptr/locked/owner state, parameterised by REQ_COUNT. The tag pipeline and RAM command registers stay in the top level.

## Test plan
- Single read: RX reads addr 3 with RAM preloaded to 512'hA5…; ram_en/addr=3 one cycle later → m_rsp_valid=2'b01 and rdata=A5… 2 cycles after the handshake.
- Contention: RX and TX both continuously read (addr 1, addr 2) for 8 cycles → grants alternate 0,1,0,1…, ram_addr alternates 1,2, and responses come back one-hot in the same order.
- Lock: TX performs read(lock=1) of addr 5, then write(lock=0) of addr 5, while RX stays valid → RX is not granted between the two TX handshakes; RX is granted on the first cycle after the TX unlock.
- Write-then-read: TX writes 512'h1234 to addr 7, then RX reads addr 7 the next cycle → the RX response is 512'h1234.
- Reset mid-flight: assert rst in the cycle after a read handshake → no m_rsp_valid ever appears for it; all outputs are 0 on the cycle after the rst edge; ptr=0 afterwards (RX wins the first contention).
- RAM_RD_LATENCY=3 build: a single read → response exactly 4 cycles after the handshake.
